regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, the next generation of the CPU register file, sitting between decode (reads), issue (hazard marking) and writeback (writes).
- Adds N read / M write ports, optional same-cycle write→read bypass, and a per-register pending scoreboard for the pipeline hazard unit.
- Adds a valid-bit lazy clear, so the async reset needs no storage flops.
- Adds a synthesizable, handshaked register-dump scanner for debug and test.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; 2**ADDR_W registers, r0 hardwired to zero.
- N_READ, 2, number of combinational read ports.
- N_WRITE, 1, number of write ports; higher port index has priority.
- BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees pre-edge storage.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  N_WRITE  per-port write enable.
- wr_addr  in  N_WRITE*ADDR_W  write addresses, packed, port 0 in LSBs.
- wr_data  in  N_WRITE*DATA_W  write data, packed.
- rd_addr  in  N_READ*ADDR_W  read addresses, packed.
- rd_data  out  N_READ*DATA_W  read data, combinational.
- rd_pending  out  N_READ  scoreboard bit for each read address.
- mark_en  in  1  issue marks a destination register as pending.
- mark_addr  in  ADDR_W  destination to mark.
- clear  in  1  synchronous zero-all request.
- dump_req  in  1  start a register scan (1-cycle pulse or level).
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_addr  out  ADDR_W  address of current beat.
- dump_data  out  DATA_W  value of current beat.
- dump_done  out  1  1-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset_n=0, async):
  - All valid bits and pending bits go to 0; scanner goes to IDLE.
  - dump_valid=0, dump_done=0, dump_addr=0.
  - Storage array is not reset.
- Read:
  - rd_data = 0 if addr==0 or valid[addr]==0, else storage[addr]. Zero latency.
- Write, at posedge, for each port with wr_en && addr!=0:
  - storage[addr] <= data; valid[addr] <= 1; pending[addr] <= 0.
  - Same address on several ports: the highest port index wins, for both data and flags.
- Bypass (BYPASS=1):
  - If any enabled write matches a read address (≠0), rd_data returns the winning wr_data and rd_pending returns 0, unless a same-cycle mark hits that address.
  - With BYPASS=0, reads return pre-edge values.
- Mark, at posedge:
  - mark_en && mark_addr!=0 sets pending[mark_addr].
  - Mark and write to the same address in one cycle: the write stores data, but pending ends at 1 (new producer wins).
  - Mark of r0 is ignored; rd_pending for r0 is always 0.
- clear, at posedge:
  - All valid and pending bits go to 0. Effective next cycle: all reads return 0.
  - Writes in the same cycle are dropped.
  - Does not disturb an active scan; the scan then reports zeros for registers not yet emitted.
- Scanner FSM, states IDLE → SCAN → DONE → IDLE:
  - IDLE: dump_req → SCAN with idx=1.
  - SCAN: dump_valid=1, dump_addr=idx, dump_data=read of idx with read-port semantics, no bypass. On dump_valid && dump_ready: if idx==2**ADDR_W-1 → DONE, else idx++.
  - dump_addr/dump_data are stable while valid && !ready, except that a write to idx updates dump_data.
  - DONE: dump_done=1 for exactly one cycle → IDLE.
  - dump_req is ignored outside IDLE.
  - Reset mid-scan → IDLE immediately.
  - Beat count is always 2**ADDR_W-1; r0 is never emitted.
- Index counter is ADDR_W bits; the last-index compare is done before increment, so there is no wrap.

Decomposition:
- Shared types package: Word (DATA_W), RegAddress (ADDR_W), scanner state enum {IDLE, SCAN, DONE}.
- One sub-module: regfile_dump_scan (FSM + index counter + handshake). It takes a read address out and read data in, and uses the main array's unbypassed read path.

Test Plan:
- Reset, then read r1..r31 → all 0, rd_pending=0; dump scan → 31 beats all data 0, dump_done pulses once.
- Port0 writes r5=7 and port1 writes r5=9 in the same cycle → next cycle r5=9; with BYPASS=1 and rd_addr0=5, rd_data0=9 combinationally in the write cycle.
- mark r3 → rd_pending=1; next write r3=4 → pending 0, data 4; mark+write r3 in the same cycle → data 4, pending 1.
- Write r0=55 and mark r0 → reads of r0 return 0, pending 0.
- Write ri=i*10+1 for all i; pulse clear → all reads 0 next cycle; a write in the clear cycle (r2=8) is dropped.
- Scan with dump_ready toggling 1,0,0,1,…: beats stay stable while stalled and come in ascending order. reset_n low at beat 10 → dump_valid=0 immediately, no dump_done.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp_pkg
// Desc   : Shared types for the multi-port register file and its dump scanner.
// Rev    : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [DATA_W_DEF-1:0] word_t;
   typedef logic [ADDR_W_DEF-1:0] reg_address_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_scan.sv
`default_nettype none
// ============================================================================
// Module : regfile_dump_scan
// Desc   : Handshaked scanner emitting r1..r(2**ADDR_W-1) from the storage read path.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_dump_scan
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dump_req,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done,
   output logic [ADDR_W-1:0] scan_addr,
   input  logic [DATA_W-1:0] scan_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   scan_state_e       state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              dump_valid_q;
   logic              dump_done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         dump_valid_q <= 1'b0;
         dump_done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               dump_done_q <= 1'b0;
               if (dump_req) begin
                  state_q      <= S_SCAN;
                  idx_q        <= ADDR_W'(1);
                  dump_valid_q <= 1'b1;
               end
            end
            S_SCAN: begin
               // Last-index test precedes the increment, so idx never wraps.
               if (dump_ready) begin
                  if (idx_q == LAST_IDX) begin
                     state_q      <= S_DONE;
                     idx_q        <= '0;
                     dump_valid_q <= 1'b0;
                     dump_done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + ADDR_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_q     <= S_IDLE;
               dump_done_q <= 1'b0;
            end
            default: begin
               state_q      <= S_IDLE;
               idx_q        <= '0;
               dump_valid_q <= 1'b0;
               dump_done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign scan_addr  = idx_q;
   assign dump_addr  = idx_q;
   assign dump_valid = dump_valid_q;
   assign dump_done  = dump_done_q;
   assign dump_data  = scan_data;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : regfile_mp
// Desc   : Multi-port register file with bypass, pending scoreboard and dump scanner.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int N_READ  = 2,
   parameter int N_WRITE = 1,
   parameter int BYPASS  = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_WRITE-1:0]         wr_en,
   input  logic [N_WRITE*ADDR_W-1:0]  wr_addr,
   input  logic [N_WRITE*DATA_W-1:0]  wr_data,
   input  logic [N_READ*ADDR_W-1:0]   rd_addr,
   output logic [N_READ*DATA_W-1:0]   rd_data,
   output logic [N_READ-1:0]          rd_pending,
   input  logic                       mark_en,
   input  logic [ADDR_W-1:0]          mark_addr,
   input  logic                       clear,
   input  logic                       dump_req,
   output logic                       dump_valid,
   input  logic                       dump_ready,
   output logic [ADDR_W-1:0]          dump_addr,
   output logic [DATA_W-1:0]          dump_data,
   output logic                       dump_done
);

   localparam int N_REG = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [N_REG];
   logic [DATA_W-1:0] mem_d [N_REG];
   logic [N_REG-1:0]  valid_q, valid_d;
   logic [N_REG-1:0]  pend_q, pend_d;

   logic [ADDR_W-1:0] scan_addr;
   logic [DATA_W-1:0] scan_data;

   // Ports are walked in ascending order so the highest index wins collisions.
   always_comb begin : p_next
      logic [ADDR_W-1:0] wa;
      wa      = '0;
      mem_d   = mem_q;
      valid_d = valid_q;
      pend_d  = pend_q;
      if (clear) begin
         valid_d = '0;
         pend_d  = '0;
      end else begin
         for (int p = 0; p < N_WRITE; p++) begin
            wa = wr_addr[p*ADDR_W +: ADDR_W];
            if (wr_en[p] && (wa != '0)) begin
               mem_d[wa]   = wr_data[p*DATA_W +: DATA_W];
               valid_d[wa] = 1'b1;
               pend_d[wa]  = 1'b0;
            end
         end
         if (mark_en && (mark_addr != '0)) begin
            pend_d[mark_addr] = 1'b1;
         end
      end
   end

   // Storage has no reset: valid bits gate every read instead.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         pend_q  <= '0;
      end else begin
         valid_q <= valid_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin : p_read
      logic [ADDR_W-1:0] ra;
      logic              hit;
      logic [DATA_W-1:0] byp;
      ra         = '0;
      hit        = 1'b0;
      byp        = '0;
      rd_data    = '0;
      rd_pending = '0;
      for (int r = 0; r < N_READ; r++) begin
         ra  = rd_addr[r*ADDR_W +: ADDR_W];
         hit = 1'b0;
         byp = '0;
         for (int p = 0; p < N_WRITE; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
               hit = 1'b1;
               byp = wr_data[p*DATA_W +: DATA_W];
            end
         end
         if (ra != '0) begin
            if ((BYPASS != 0) && hit) begin
               rd_data[r*DATA_W +: DATA_W] = byp;
               rd_pending[r]               = mark_en && (mark_addr == ra);
            end else begin
               rd_data[r*DATA_W +: DATA_W] = valid_q[ra] ? mem_q[ra] : '0;
               rd_pending[r]               = pend_q[ra];
            end
         end
      end
   end

   assign scan_data = ((scan_addr != '0) && valid_q[scan_addr]) ? mem_q[scan_addr] : '0;

   regfile_dump_scan #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_scan (
      .clk        (clk),
      .reset_n    (reset_n),
      .dump_req   (dump_req),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done),
      .scan_addr  (scan_addr),
      .scan_data  (scan_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_mp
// Desc   : Self-checking bench for regfile_mp against a value-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NR  = 2;
   localparam int NW  = 2;
   localparam int NRG = 32;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NW-1:0]    wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_pending;
   logic             mark_en;
   logic [AW-1:0]    mark_addr;
   logic             clear;
   logic             dump_req;
   logic             dump_valid;
   logic             dump_ready;
   logic [AW-1:0]    dump_addr;
   logic [DW-1:0]    dump_data;
   logic             dump_done;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] regs_m [NRG];
   bit            pend_m [NRG];

   regfile_mp #(
      .DATA_W (DW), .ADDR_W (AW), .N_READ (NR), .N_WRITE (NW), .BYPASS (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_pending (rd_pending),
      .mark_en    (mark_en),
      .mark_addr  (mark_addr),
      .clear      (clear),
      .dump_req   (dump_req),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NRG; i++) begin
         regs_m[i] = '0;
         pend_m[i] = 1'b0;
      end
   endtask

   // Architectural effect of one clock edge given the inputs currently applied.
   task automatic model_edge();
      int a;
      if (clear) begin
         model_reset();
      end else begin
         for (int p = 0; p < NW; p++) begin
            a = int'(wr_addr[p*AW +: AW]);
            if (wr_en[p] && a != 0) begin
               regs_m[a] = wr_data[p*DW +: DW];
               pend_m[a] = 1'b0;
            end
         end
         if (mark_en && mark_addr != 0) pend_m[int'(mark_addr)] = 1'b1;
      end
   endtask

   function automatic void exp_read(input int a, output logic [DW-1:0] d, output bit pd);
      int win;
      win = -1;
      d   = '0;
      pd  = 1'b0;
      if (a != 0) begin
         for (int p = 0; p < NW; p++)
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) win = p;
         if (win >= 0) begin
            d  = wr_data[win*DW +: DW];
            pd = mark_en && (int'(mark_addr) == a);
         end else begin
            d  = regs_m[a];
            pd = pend_m[a];
         end
      end
   endfunction

   task automatic check_reads(input string tag);
      logic [DW-1:0] d;
      bit            pd;
      #1;
      for (int r = 0; r < NR; r++) begin
         exp_read(int'(rd_addr[r*AW +: AW]), d, pd);
         chk($sformatf("%s rd_data%0d a=%0d", tag, r, rd_addr[r*AW +: AW]), 64'(rd_data[r*DW +: DW]), 64'(d));
         chk($sformatf("%s rd_pend%0d a=%0d", tag, r, rd_addr[r*AW +: AW]), 64'(rd_pending[r]), 64'(pd));
      end
   endtask

   task automatic idle_inputs();
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      mark_en   = 1'b0;
      mark_addr = '0;
      clear     = 1'b0;
      dump_req  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic write1(input int p, input int a, input logic [DW-1:0] v);
      wr_en[p]              = 1'b1;
      wr_addr[p*AW +: AW]   = AW'(a);
      wr_data[p*DW +: DW]   = v;
   endtask

   // Runs one scan with ready pattern 1,0,0 repeating; optional reset at beat 10.
   task automatic run_scan(input string tag, input bit do_reset);
      int  exp_idx;
      int  cyc;
      int  k;
      int  dones;
      bit  acc;
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      exp_idx  = 1;
      cyc      = 0;
      k        = 0;
      while (exp_idx <= NRG-1 && cyc < 500) begin
         dump_ready = (k % 3 == 0);
         k++;
         if (do_reset && exp_idx == 10) begin
            reset_n = 1'b0;
            #1;
            chk({tag, " rst dump_valid"}, 64'(dump_valid), 64'(0));
            chk({tag, " rst dump_done"}, 64'(dump_done), 64'(0));
            @(posedge clk);
            model_reset();
            @(negedge clk);
            reset_n    = 1'b1;
            dump_ready = 1'b1;
            dones      = 0;
            for (int i = 0; i < 40; i++) begin
               #1;
               if (dump_done || dump_valid) dones++;
               tick();
            end
            chk({tag, " no activity after reset"}, 64'(dones), 64'(0));
            return;
         end
         #1;
         chk($sformatf("%s valid idx=%0d", tag, exp_idx), 64'(dump_valid), 64'(1));
         chk($sformatf("%s addr idx=%0d", tag, exp_idx), 64'(dump_addr), 64'(exp_idx));
         chk($sformatf("%s data idx=%0d", tag, exp_idx), 64'(dump_data), 64'(regs_m[exp_idx]));
         chk($sformatf("%s no early done idx=%0d", tag, exp_idx), 64'(dump_done), 64'(0));
         acc = dump_ready;
         tick();
         if (acc) exp_idx++;
         cyc++;
      end
      chk({tag, " scan finished in budget"}, 64'(exp_idx), 64'(NRG));
      dump_ready = 1'b0;
      #1;
      chk({tag, " done pulse"}, 64'(dump_done), 64'(1));
      chk({tag, " valid low at done"}, 64'(dump_valid), 64'(0));
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         if (dump_done) dones++;
      end
      chk({tag, " single done pulse"}, 64'(dones), 64'(0));
   endtask

   initial begin
      reset_n    = 1'b0;
      dump_ready = 1'b0;
      rd_addr    = '0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset dump_valid", 64'(dump_valid), 64'(0));
      chk("reset dump_done", 64'(dump_done), 64'(0));
      chk("reset dump_addr", 64'(dump_addr), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;

      // Post-reset: every register reads zero, nothing pending.
      for (int i = 1; i < NRG; i++) begin
         rd_addr = {AW'(NRG - i), AW'(i)};
         check_reads("post-reset");
      end
      @(negedge clk);
      run_scan("scan-zero", 1'b0);

      // Same-address write on both ports: port 1 wins, bypassed combinationally.
      write1(0, 5, 32'd7);
      write1(1, 5, 32'd9);
      rd_addr = {AW'(0), AW'(5)};
      check_reads("dual-write bypass");
      chk("dual-write bypass direct", 64'(rd_data[DW-1:0]), 64'(9));
      tick();
      idle_inputs();
      check_reads("dual-write after");
      chk("dual-write r5 direct", 64'(rd_data[DW-1:0]), 64'(9));

      // Scoreboard mark / write / mark+write.
      mark_en = 1'b1; mark_addr = AW'(3);
      tick();
      idle_inputs();
      rd_addr = {AW'(5), AW'(3)};
      check_reads("mark r3");
      chk("mark r3 pending direct", 64'(rd_pending[0]), 64'(1));
      write1(0, 3, 32'd4);
      tick();
      idle_inputs();
      check_reads("write r3 clears pending");
      write1(0, 3, 32'd4);
      mark_en = 1'b1; mark_addr = AW'(3);
      check_reads("mark+write r3 comb");
      tick();
      idle_inputs();
      check_reads("mark+write r3 after");
      chk("mark+write r3 pending direct", 64'(rd_pending[0]), 64'(1));
      chk("mark+write r3 data direct", 64'(rd_data[DW-1:0]), 64'(4));

      // r0 is immutable and never pending.
      write1(0, 0, 32'd55);
      mark_en = 1'b1; mark_addr = '0;
      rd_addr = {AW'(0), AW'(0)};
      check_reads("r0 comb");
      tick();
      idle_inputs();
      check_reads("r0 after");

      // Fill, then clear with a dropped same-cycle write.
      for (int i = 1; i < NRG; i++) begin
         write1(0, i, DW'(i * 10 + 1));
         tick();
      end
      idle_inputs();
      rd_addr = {AW'(31), AW'(2)};
      check_reads("filled");
      clear = 1'b1;
      write1(0, 2, 32'd8);
      tick();
      idle_inputs();
      for (int i = 1; i < NRG; i++) begin
         rd_addr = {AW'(NRG - i), AW'(i)};
         check_reads("post-clear");
      end
      rd_addr = {AW'(2), AW'(2)};
      #1;
      chk("clear drops r2 write", 64'(rd_data[DW-1:0]), 64'(0));
      @(negedge clk);

      // Randomised traffic with collisions, marks and rare clears.
      for (int n = 0; n < 400; n++) begin
         wr_en     = NW'($urandom_range(0, 3));
         wr_addr[AW-1:0]    = AW'($urandom);
         wr_addr[2*AW-1:AW] = ($urandom_range(0, 3) == 0) ? wr_addr[AW-1:0] : AW'($urandom);
         wr_data   = {$urandom, $urandom};
         mark_en   = ($urandom_range(0, 2) == 0);
         mark_addr = ($urandom_range(0, 3) == 0) ? wr_addr[AW-1:0] : AW'($urandom);
         clear     = ($urandom_range(0, 31) == 0);
         rd_addr[AW-1:0]    = ($urandom_range(0, 2) == 0) ? wr_addr[2*AW-1:AW] : AW'($urandom);
         rd_addr[2*AW-1:AW] = AW'($urandom);
         if (clear) begin
            #1;
            for (int r = 0; r < NR; r++) ;
         end else begin
            check_reads("random");
         end
         tick();
      end
      idle_inputs();

      // Scans over non-zero contents with a stalling consumer.
      for (int i = 1; i < NRG; i++) begin
         write1(1, i, DW'($urandom));
         tick();
      end
      idle_inputs();
      run_scan("scan-stall", 1'b0);
      run_scan("scan-reset", 1'b1);
      rd_addr = {AW'(17), AW'(4)};
      check_reads("after mid-scan reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
